matmul_slot: RTL and testbench

Parametrised matrix-multiply accelerator with on-chip operand and result buffers, attached to the MCU I/O slot bus through the standard cs/read/write register interface. It is the self-contained successor to the DMA-based matrix wrapper. Software loads A and B through auto-incrementing data windows, starts the operation and polls STATUS or waits on `irq`. It then reads C back through an auto-incrementing window. Dimensions are runtime-programmable up to `MAX_DIM`.

---
 rtl/matmul_slot_if.sv | 14 +
 rtl/matmul_slot.sv | 199 +++++++++++++++++++
 tb/tb_matmul_slot.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_slot_if.sv
// Slot-bus register interface for matmul_slot: cs/read/write strobes, word address,
// write/read data and the interrupt line.
interface matmul_slot_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq;

    modport master (output cs, read, write, addr, wr_data, input rd_data, irq);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data, irq);
endinterface

// File: rtl/matmul_slot.sv
// Matrix-multiply slot peripheral: A/B operand buffers, C result buffer, one MAC per cycle,
// programmable M x N x P up to MAX_DIM, with busy/done/err status and an interrupt.
module matmul_slot #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MAX_DIM = 8
) (
    input logic          clk,
    input logic          reset,
    matmul_slot_if.slave bus
);
    localparam int unsigned DEPTH   = MAX_DIM * MAX_DIM;
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  MAX_D8  = 8'(MAX_DIM);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;

    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];
    logic [31:0]       c_mem [DEPTH];

    logic [1:0]       state_q, state_d;
    logic             done_q, done_d, err_q, err_d, irq_en_q, irq_en_d;
    logic [7:0]       m_q, m_d, n_q, n_d, p_q, p_d;
    logic [7:0]       i_q, i_d, j_q, j_d, k_q, k_d;
    logic [PTR_W-1:0] a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, c_ptr_q, c_ptr_d;
    logic [31:0]      acc_q, acc_d, cycles_q, cycles_d;
    logic             a_we, b_we, c_we;

    logic                      busy, wr_en, rd_en, dim_ok;
    logic [15:0]               a_lin, b_lin, c_lin;
    logic [PTR_W-1:0]          a_idx, b_idx, c_idx;
    logic signed [2*DATA_W-1:0] prod;
    logic                      unused_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign busy   = (state_q != S_IDLE);
    assign wr_en  = bus.cs & bus.write & ~reset;
    assign rd_en  = bus.cs & bus.read;
    assign dim_ok = (m_q != 8'd0) && (m_q <= MAX_D8) && (n_q != 8'd0) && (n_q <= MAX_D8)
                 && (p_q != 8'd0) && (p_q <= MAX_D8);

    assign a_lin = 16'(i_q) * 16'(n_q) + 16'(k_q);
    assign b_lin = 16'(k_q) * 16'(p_q) + 16'(j_q);
    assign c_lin = 16'(i_q) * 16'(p_q) + 16'(j_q);
    assign a_idx = PTR_W'(a_lin);
    assign b_idx = PTR_W'(b_lin);
    assign c_idx = PTR_W'(c_lin);
    assign prod  = $signed(a_mem[a_idx]) * $signed(b_mem[b_idx]);
    assign unused_wr = ^bus.wr_data;

    // Next-state: bus register decode plus the MAC/STORE sequencer
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        err_d    = err_q;
        irq_en_d = irq_en_q;
        m_d = m_q;  n_d = n_q;  p_d = p_q;
        i_d = i_q;  j_d = j_q;  k_d = k_q;
        a_ptr_d  = a_ptr_q;
        b_ptr_d  = b_ptr_q;
        c_ptr_d  = c_ptr_q;
        acc_d    = acc_q;
        cycles_d = cycles_q;
        a_we = 1'b0;
        b_we = 1'b0;
        c_we = 1'b0;

        if (wr_en) begin
            case (bus.addr)
                5'd0: begin
                    irq_en_d = bus.wr_data[2];
                    if (!busy) begin
                        if (bus.wr_data[0]) begin
                            if (dim_ok) begin
                                state_d  = S_MAC;
                                done_d   = 1'b0;
                                err_d    = 1'b0;
                                cycles_d = '0;
                                i_d = '0;  j_d = '0;  k_d = '0;
                                acc_d = '0;
                            end else begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end
                        end else if (bus.wr_data[1]) begin
                            done_d = 1'b0;
                            err_d  = 1'b0;
                        end
                    end
                end
                5'd2: if (!busy) begin
                    m_d = bus.wr_data[7:0];
                    n_d = bus.wr_data[15:8];
                    p_d = bus.wr_data[23:16];
                end
                5'd3: if (!busy) a_ptr_d = PTR_W'(bus.wr_data);
                5'd4: if (!busy) begin
                    a_we    = 1'b1;
                    a_ptr_d = ptr_inc(a_ptr_q);
                end
                5'd5: if (!busy) b_ptr_d = PTR_W'(bus.wr_data);
                5'd6: if (!busy) begin
                    b_we    = 1'b1;
                    b_ptr_d = ptr_inc(b_ptr_q);
                end
                5'd7: if (!busy) c_ptr_d = PTR_W'(bus.wr_data);
                default: ;
            endcase
        end

        if (rd_en && bus.addr == 5'd8) c_ptr_d = ptr_inc(c_ptr_q);

        case (state_q)
            S_MAC: begin
                acc_d    = acc_q + 32'(prod);
                cycles_d = cycles_q + 32'd1;
                if (k_q == n_q - 8'd1) state_d = S_STORE;
                else                   k_d = k_q + 8'd1;
            end
            S_STORE: begin
                c_we     = ~reset;
                acc_d    = '0;
                k_d      = '0;
                cycles_d = cycles_q + 32'd1;
                state_d  = S_MAC;
                if (j_q == p_q - 8'd1) begin
                    j_d = '0;
                    if (i_q == m_q - 8'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        i_d     = '0;
                    end else begin
                        i_d = i_q + 8'd1;
                    end
                end else begin
                    j_d = j_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
            m_q <= 8'd1;  n_q <= 8'd1;  p_q <= 8'd1;
            i_q <= '0;    j_q <= '0;    k_q <= '0;
            a_ptr_q  <= '0;
            b_ptr_q  <= '0;
            c_ptr_q  <= '0;
            acc_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_en_q <= irq_en_d;
            m_q <= m_d;  n_q <= n_d;  p_q <= p_d;
            i_q <= i_d;  j_q <= j_d;  k_q <= k_d;
            a_ptr_q  <= a_ptr_d;
            b_ptr_q  <= b_ptr_d;
            c_ptr_q  <= c_ptr_d;
            acc_q    <= acc_d;
            cycles_q <= cycles_d;
        end
    end

    // Buffers are deliberately not reset; a run cut short leaves partial C behind
    always_ff @(posedge clk) begin
        if (a_we) a_mem[a_ptr_q] <= bus.wr_data[DATA_W-1:0];
        if (b_we) b_mem[b_ptr_q] <= bus.wr_data[DATA_W-1:0];
        if (c_we) c_mem[c_idx]   <= acc_q;
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            5'd0: bus.rd_data = {29'd0, irq_en_q, 2'd0};
            5'd1: bus.rd_data = {29'd0, err_q, done_q, busy};
            5'd2: bus.rd_data = {8'd0, p_q, n_q, m_q};
            5'd3: bus.rd_data = 32'(a_ptr_q);
            5'd5: bus.rd_data = 32'(b_ptr_q);
            5'd7: bus.rd_data = 32'(c_ptr_q);
            5'd8: bus.rd_data = c_mem[c_ptr_q];
            5'd9: bus.rd_data = cycles_q;
            default: ;
        endcase
    end

    assign bus.irq = done_q & irq_en_q;
endmodule

// File: tb/tb_matmul_slot.sv
// Directed bench for matmul_slot: matrix products, signed and wrap arithmetic,
// invalid dimensions, busy write protection, interrupt and mid-run reset.
module tb_matmul_slot;
    localparam logic [4:0] R_CTRL = 5'd0, R_STAT = 5'd1, R_DIM = 5'd2, R_APTR = 5'd3,
                           R_ADAT = 5'd4, R_BPTR = 5'd5, R_BDAT = 5'd6, R_CPTR = 5'd7,
                           R_CDAT = 5'd8, R_CYC = 5'd9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matmul_slot_if bus();
    matmul_slot #(.DATA_W(16), .MAX_DIM(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.write = 1'b1; bus.read = 1'b0; bus.addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.addr = a;
        #1 d = bus.rd_data;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(tag, v, exp);
    endtask

    // Poll STATUS once per cycle; returns how many polls saw busy before it dropped
    task automatic wait_done(input int max, output int cnt);
        logic [31:0] s;
        bit          idle;
        cnt  = 0;
        idle = 1'b0;
        for (int c = 0; c < max && !idle; c++) begin
            rd(R_STAT, s);
            if (s[0]) cnt++;
            else      idle = 1'b1;
        end
        if (!idle) begin
            n_asserts++;
            n_fail++;
            $error("FAIL wait_done: busy still set after %0d cycles, expected idle", max);
        end
    endtask

    task automatic load_2x3_3x2();
        wr(R_APTR, 32'd0);
        for (int i = 1; i <= 6; i++) wr(R_ADAT, 32'(i));
        wr(R_BPTR, 32'd0);
        for (int i = 7; i <= 12; i++) wr(R_BDAT, 32'(i));
        wr(R_DIM, 32'h0002_0302);
    endtask

    task automatic check_c_2x3_3x2(input string pfx);
        wr(R_CPTR, 32'd0);
        rd_check({pfx, "_c00"}, R_CDAT, 32'd58);
        rd_check({pfx, "_c01"}, R_CDAT, 32'd64);
        rd_check({pfx, "_c10"}, R_CDAT, 32'd139);
        rd_check({pfx, "_c11"}, R_CDAT, 32'd154);
        rd_check({pfx, "_cptr_end"}, R_CPTR, 32'd4);
    endtask

    initial begin
        int cnt;
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        rd_check("rst_status", R_STAT, 32'd0);
        rd_check("rst_dim", R_DIM, 32'h0001_0101);
        rd_check("rst_cycles", R_CYC, 32'd0);
        rd_check("rst_aptr", R_APTR, 32'd0);
        rd_check("unmapped_rd", 5'd15, 32'd0);

        // Pointer wrap at the top of the buffer
        wr(R_APTR, 32'd63);
        wr(R_ADAT, 32'd0);
        rd_check("aptr_wrap", R_APTR, 32'd0);
        wr(R_BPTR, 32'd66);
        rd_check("bptr_lowbits", R_BPTR, 32'd2);

        // 2x3 * 3x2
        load_2x3_3x2();
        wr(R_CTRL, 32'd1);
        wait_done(200, cnt);
        check("mm_busy_len", 32'(cnt), 32'd16);
        rd_check("mm_status", R_STAT, 32'd2);
        rd_check("mm_cycles", R_CYC, 32'd16);
        check_c_2x3_3x2("mm");

        // Signed 1x1x1: -1 * 3
        wr(R_DIM, 32'h0001_0101);
        wr(R_APTR, 32'd0);
        wr(R_ADAT, 32'h0000_FFFF);
        wr(R_BPTR, 32'd0);
        wr(R_BDAT, 32'd3);
        wr(R_CTRL, 32'd1);
        wait_done(50, cnt);
        check("sgn_busy_len", 32'(cnt), 32'd2);
        wr(R_CPTR, 32'd0);
        rd_check("sgn_c", R_CDAT, 32'hFFFF_FFFD);

        // Accumulator wraps modulo 2^32
        wr(R_DIM, 32'h0001_0801);
        wr(R_APTR, 32'd0);
        for (int i = 0; i < 8; i++) wr(R_ADAT, 32'h7FFF);
        wr(R_BPTR, 32'd0);
        for (int i = 0; i < 8; i++) wr(R_BDAT, 32'h7FFF);
        wr(R_CTRL, 32'd1);
        wait_done(100, cnt);
        check("wrap_busy_len", 32'(cnt), 32'd9);
        rd_check("wrap_cycles", R_CYC, 32'd9);
        wr(R_CPTR, 32'd0);
        rd_check("wrap_c", R_CDAT, 32'hFFF8_0008);

        // Invalid DIM (N=0)
        wr(R_DIM, 32'h0001_0001);
        wr(R_CTRL, 32'd1);
        rd_check("inv_status_t1", R_STAT, 32'd6);
        rd_check("inv_status_t2", R_STAT, 32'd6);
        wr(R_CPTR, 32'd0);
        rd_check("inv_c_kept", R_CDAT, 32'hFFF8_0008);
        wr(R_CTRL, 32'd2);
        rd_check("inv_cleared", R_STAT, 32'd0);

        // Writes during a run are ignored
        load_2x3_3x2();
        wr(R_CTRL, 32'd1);
        wr(R_ADAT, 32'd99);
        wr(R_DIM, 32'd0);
        wr(R_CPTR, 32'd5);
        wait_done(200, cnt);
        rd_check("prot_status", R_STAT, 32'd2);
        rd_check("prot_cycles", R_CYC, 32'd16);
        rd_check("prot_aptr", R_APTR, 32'd6);
        rd_check("prot_dim", R_DIM, 32'h0002_0302);
        check_c_2x3_3x2("prot");

        // Interrupt
        wr(R_CTRL, 32'd6);
        rd_check("irq_ctrl_rd", R_CTRL, 32'd4);
        rd_check("irq_cleared_status", R_STAT, 32'd0);
        check("irq_low_before", 32'(bus.irq), 32'd0);
        wr(R_CTRL, 32'd5);
        check("irq_low_busy", 32'(bus.irq), 32'd0);
        wait_done(200, cnt);
        check("irq_high_done", 32'(bus.irq), 32'd1);
        wr(R_CTRL, 32'd6);
        check("irq_low_clear", 32'(bus.irq), 32'd0);

        // Reset in the middle of a run
        wr(R_CTRL, 32'd5);
        rd_check("rst_run_busy", R_STAT, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rd_check("rst_mid_status", R_STAT, 32'd0);
        rd_check("rst_mid_dim", R_DIM, 32'h0001_0101);
        rd_check("rst_mid_ctrl", R_CTRL, 32'd0);
        rd_check("rst_mid_aptr", R_APTR, 32'd0);
        rd_check("rst_mid_bptr", R_BPTR, 32'd0);
        rd_check("rst_mid_cptr", R_CPTR, 32'd0);
        rd_check("rst_mid_cycles", R_CYC, 32'd0);
        check("rst_mid_irq", 32'(bus.irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
